// File: rtl/dram_fill_verify.sv
// dram_fill_verify
// Streams words into a distributed RAM through its write port, then reads the
// same region back over the asynchronous spo port and compares additive
// checksums of what was written against what was read.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   start      begin a run (only honoured in IDLE)
//   length     words to write, clamped to DEPTH, captured on start
//   s_data     input word
//   s_valid    input word valid
//   s_ready    block can take s_data this cycle
//   ram_a      RAM address (registered)
//   ram_d      RAM write data (registered)
//   ram_we     RAM write enable (registered)
//   ram_spo    RAM asynchronous read data at ram_a
//   busy       any state other than IDLE
//   done       one-cycle end-of-run pulse
//   verify_err checksum mismatch of the last run, held until the next start
//   wr_sum     sum of written words mod 2^DATA_W
//   rd_sum     sum of read-back words mod 2^DATA_W
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | accepting words, one RAM write per handshake
// FLUSH  | lets the final registered write land before reading
// VERIFY | summing ram_spo over addresses 0..len-1
// DONE   | done pulse, checksum compare
`timescale 1ns/1ps
module dram_fill_verify #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_spo,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [DATA_W-1:0] wr_sum,
  output logic [DATA_W-1:0] rd_sum
);

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, VERIFY, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t          state, state_nxt;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wr_cnt;
  logic            hs;
  logic            last_wr;
  logic            last_rd;

  assign s_ready = (state == FILL) && (wr_cnt < len);
  assign hs      = s_valid && s_ready;
  assign last_wr = (wr_cnt == len - 1'b1);
  assign last_rd = ({1'b0, ram_a} == len - 1'b1);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? DONE : FILL;
      FILL:    if (hs && last_wr) state_nxt = FLUSH;
      FLUSH:   state_nxt = VERIFY;
      VERIFY:  if (last_rd) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len        <= '0;
      wr_cnt     <= '0;
      ram_a      <= '0;
      ram_d      <= '0;
      ram_we     <= 1'b0;
      verify_err <= 1'b0;
      wr_sum     <= '0;
      rd_sum     <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len        <= (length > DEPTH_L) ? DEPTH_L : length;
            wr_cnt     <= '0;
            wr_sum     <= '0;
            rd_sum     <= '0;
            verify_err <= 1'b0;
          end
        end
        FILL: begin
          if (hs) begin
            ram_we <= 1'b1;
            ram_a  <= wr_cnt[ADDR_W-1:0];
            ram_d  <= s_data;
            wr_sum <= wr_sum + s_data;
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        // The last write is on the RAM port during this cycle; the read
        // pointer moves to 0 only once that write has committed.
        FLUSH: ram_a <= '0;
        VERIFY: begin
          rd_sum <= rd_sum + ram_spo;
          ram_a  <= ram_a + 1'b1;
        end
        DONE: verify_err <= (wr_sum != rd_sum);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_fill_verify.sv
`timescale 1ns/1ps
module tb_dram_fill_verify;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] length;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [10:0] ram_a;
  logic [15:0] ram_d;
  logic        ram_we;
  logic [15:0] ram_spo;
  logic        busy;
  logic        done;
  logic        verify_err;
  logic [15:0] wr_sum;
  logic [15:0] rd_sum;

  logic [15:0] mem [2048];
  logic [15:0] words [2048];
  logic        fault;
  sb_t         sb [$];
  int          n_chk;
  int          n_fail;
  int          n_writes;
  logic [10:0] last_addr;

  dram_fill_verify dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo),
    .busy(busy), .done(done), .verify_err(verify_err),
    .wr_sum(wr_sum), .rd_sum(rd_sum)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // RAM model: synchronous write, asynchronous read, optional stuck-at-0 on bit 15
  always @(posedge clk) if (ram_we === 1'b1) mem[ram_a] <= ram_d;
  assign ram_spo = fault ? (mem[ram_a] & 16'h7FFF) : mem[ram_a];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("wr_addr", ram_a, e.addr);
        chk("wr_data", ram_d, e.data);
        last_addr = ram_a;
        n_writes++;
      end
    end
  end

  task automatic run(input int len_req, input int n_words, input bit gaps,
                     input bit fault_en, input int exp_lat, input bit glitch);
    int cyc, idx;
    bit tog, hs;
    logic [15:0] ews, ers;
    sb_t e;
    fault = fault_en;
    ews = '0;
    ers = '0;
    for (int i = 0; i < n_words; i++) begin
      ews = ews + words[i];
      ers = ers + (fault_en ? (words[i] & 16'h7FFF) : words[i]);
    end
    n_writes = 0;
    @(negedge clk);
    length  = len_req[11:0];
    start   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    idx = 0;
    tog = 1'b1;
    while (done !== 1'b1 && cyc < 10000) begin
      if (glitch && cyc == 2) begin start = 1'b1; length = 12'd1; end
      else start = 1'b0;
      if (idx < n_words) begin s_valid = gaps ? tog : 1'b1; s_data = words[idx]; end
      else begin s_valid = gaps; s_data = 16'hDEAD; end
      hs = s_valid && s_ready;
      if (hs) begin
        if (idx < n_words) begin
          e.addr = idx[10:0];
          e.data = s_data;
          sb.push_back(e);
          idx++;
        end else chk("extra_accept", 1, 0);
      end
      tog = !tog;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("done", done, 1);
    if (exp_lat >= 0) chk("done_lat", cyc, exp_lat);
    chk("wr_sum", wr_sum, ews);
    chk("rd_sum", rd_sum, ers);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("verify_err", verify_err, (ews != ers));
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("sb_empty", sb.size(), 0);
    chk("n_writes", n_writes, n_words);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    sb_t e;
    n_chk = 0;
    n_fail = 0;
    n_writes = 0;
    last_addr = '0;
    fault = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    length = '0;
    s_data = '0;
    s_valid = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_verify_err", verify_err, 0);
    chk("rst_wr_sum", wr_sum, 0);
    chk("rst_rd_sum", rd_sum, 0);
    chk("rst_s_ready", s_ready, 0);

    // basic: 1..4, valid held high
    for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
    run(4, 4, 1'b0, 1'b0, 10, 1'b0);
    chk("basic_sum", wr_sum, 16'h000A);

    // gaps on s_valid, then extra valid beats must not be taken
    words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0F0F;
    run(3, 3, 1'b1, 1'b0, -1, 1'b0);

    // stuck bit 15 on read-back
    words[0] = 16'h8000; words[1] = 16'h0001;
    run(2, 2, 1'b0, 1'b1, 6, 1'b0);
    chk("fault_wr_sum", wr_sum, 16'h8001);
    chk("fault_rd_sum", rd_sum, 16'h0001);
    chk("fault_err", verify_err, 1);

    // clean run clears the error; start pulsed mid-FILL is ignored
    for (int i = 0; i < 5; i++) words[i] = 16'(16'h0100 * (i + 3));
    run(5, 5, 1'b0, 1'b0, 12, 1'b1);

    // zero length
    run(0, 0, 1'b0, 1'b0, 1, 1'b0);

    // full depth, all ones
    for (int i = 0; i < 2048; i++) words[i] = 16'hFFFF;
    run(2048, 2048, 1'b0, 1'b0, 4098, 1'b0);
    chk("full_last_addr", last_addr, 11'h7FF);
    chk("full_wr_sum", wr_sum, 16'hF800);

    // oversize length is clamped to depth
    for (int i = 0; i < 2048; i++) words[i] = 16'(i * 7 + 3);
    run(4095, 2048, 1'b0, 1'b0, 4098, 1'b0);
    chk("clamp_last_addr", last_addr, 11'h7FF);

    // abort after 2 of 5 beats
    for (int i = 0; i < 5; i++) words[i] = 16'(16'h0011 * (i + 1));
    @(negedge clk);
    length = 12'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = words[i];
      chk("abort_ready", s_ready, 1);
      e.addr = i[10:0];
      e.data = words[i];
      sb.push_back(e);
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_a", ram_a, 0);
    chk("abort_wr_sum", wr_sum, 0);
    chk("abort_s_ready", s_ready, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | (done === 1'b1);
    end
    chk("abort_no_done", seen, 0);
    chk("abort_sb_empty", sb.size(), 0);

    // recovery run
    for (int i = 0; i < 5; i++) words[i] = 16'($urandom_range(0, 65535));
    run(5, 5, 1'b0, 1'b0, 12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
